prog_ctrl: RTL

- Program sequencer and branch-resolution unit sitting directly upstream of the instruction-fetch stage.
- Drives the fetch stage's Init, ProgState, Branch_en, FLAG_IN and Target inputs, and consumes its Halt output.
- Launches one of three programs by forcing a one-cycle jump to that program's start address.
- Holds the 1-bit condition flag, resolves decoded branches through a 32-entry target LUT, and counts execution cycles with a watchdog.

---
 rtl/prog_pkg.sv | 30 +++
 rtl/branch_lut.sv | 11 +
 rtl/prog_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/prog_pkg.sv
// Shared types and constants for the program sequencer: FSM states, widths
// and the branch-target ROM contents.
package prog_pkg;

  localparam int PC_W  = 10;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LAUNCH = 2'b01,
    RUN    = 2'b10,
    DONE   = 2'b11
  } state_t;

  // Branch targets indexed by the decoder's BrIdx; unlisted slots point at 0.
  localparam logic [PC_W-1:0] TARGET_LUT [32] = '{
    0:       10'd16,
    1:       10'd40,
    2:       10'd64,
    3:       10'd129,
    5:       10'd200,
    7:       10'd300,
    10:      10'd512,
    15:      10'd700,
    20:      10'd1000,
    31:      10'd1023,
    default: 10'd0
  };

endpackage

// File: rtl/branch_lut.sv
// Combinational 32x10 branch-target ROM.
module branch_lut
  import prog_pkg::*;
(
  input  logic [4:0]      idx,
  output logic [PC_W-1:0] target
);

  assign target = TARGET_LUT[idx];

endmodule

// File: rtl/prog_ctrl.sv
// Program sequencer feeding the fetch stage: launches programs, resolves
// branches through the target ROM, holds the condition flag and the watchdog.
module prog_ctrl
  import prog_pkg::*;
#(
  parameter logic [PC_W-1:0]  P1_START   = 10'd0,
  parameter logic [PC_W-1:0]  P2_START   = 10'd128,
  parameter logic [PC_W-1:0]  P3_START   = 10'd256,
  parameter logic [CNT_W-1:0] MAX_CYCLES = 16'd4000
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [1:0]       ProgSel,
  input  logic             Halt,
  input  logic             BrReq,
  input  logic             BrUncond,
  input  logic [4:0]       BrIdx,
  input  logic             FlagWe,
  input  logic             FlagD,
  output logic             Init,
  output logic [1:0]       ProgState,
  output logic             Branch_en,
  output logic             FLAG_IN,
  output logic [PC_W-1:0]  Target,
  output logic             Done,
  output logic             Timeout,
  output logic [CNT_W-1:0] CycleCnt
);

  state_t          state;
  logic            flag_q;
  logic [1:0]      prog_q;
  logic [PC_W-1:0] lut_target;
  logic [PC_W-1:0] launch_target;
  logic            launch_req;

  branch_lut u_lut (
    .idx    (BrIdx),
    .target (lut_target)
  );

  assign launch_req = Start && (ProgSel != 2'd0);

  always_comb begin
    launch_target = '0;
    case (prog_q)
      2'd1:    launch_target = P1_START;
      2'd2:    launch_target = P2_START;
      2'd3:    launch_target = P3_START;
      default: launch_target = '0;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      flag_q    <= 1'b0;
      prog_q    <= 2'd0;
      CycleCnt  <= '0;
      Timeout   <= 1'b0;
      Init      <= 1'b1;
      ProgState <= 2'd0;
      Done      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // Clearing on entry makes LAUNCH already show a fresh run.
          if (launch_req) begin
            state     <= LAUNCH;
            prog_q    <= ProgSel;
            ProgState <= ProgSel;
            Init      <= 1'b0;
            Done      <= 1'b0;
            flag_q    <= 1'b0;
            CycleCnt  <= '0;
            Timeout   <= 1'b0;
          end
        end
        LAUNCH: state <= RUN;
        RUN: begin
          if (FlagWe) flag_q <= FlagD;
          if (CycleCnt != '1) CycleCnt <= CycleCnt + 16'd1;
          // Halt has priority over the watchdog.
          if (Halt) begin
            state   <= DONE;
            Init    <= 1'b1;
            Done    <= 1'b1;
            Timeout <= 1'b0;
          end else if (CycleCnt == MAX_CYCLES - 16'd1) begin
            state   <= DONE;
            Init    <= 1'b1;
            Done    <= 1'b1;
            Timeout <= 1'b1;
          end
        end
      endcase
    end
  end

  // NOTE: defaults first so no path leaves an output unassigned (no latch).
  always_comb begin
    Branch_en = 1'b0;
    FLAG_IN   = 1'b0;
    Target    = '0;
    case (state)
      LAUNCH: begin
        Branch_en = 1'b1;
        FLAG_IN   = 1'b1;
        Target    = launch_target;
      end
      RUN: begin
        Branch_en = BrReq;
        FLAG_IN   = BrUncond | flag_q;
        Target    = lut_target;
      end
      default: ;
    endcase
  end

endmodule
